// File: rtl/uart_rx_deframer.sv
// ---------------------------------------------------------------------------
// uart_rx_deframer: 8N1 UART receiver with 16x oversampling and runtime divider
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_rx_deframer #(
  parameter logic [15:0] DEFAULT_CLOCK_DIV = 16'd54
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_phy_uart_in,
  input  logic        i_set_clock_div,
  input  logic [15:0] i_user_clock_div,
  output logic [7:0]  o_rx_byte,
  output logic        o_received,
  output logic        o_rx_error,
  output logic        o_is_receiving,
  output logic [15:0] o_clock_div
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        sync1_q, sync2_q;
  logic [15:0] clock_div_q, clock_div_d;
  logic [15:0] tick_cnt_q, tick_cnt_d;
  logic [3:0]  os_cnt_q, os_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        received_q, received_d;
  logic        rx_error_q, rx_error_d;

  logic [15:0] w_eff_div;
  logic        w_tick;
  logic        w_rx;

  assign w_rx      = sync2_q;
  assign w_eff_div = (clock_div_q == 16'd0) ? 16'd1 : clock_div_q;
  // >= so a divider shrunk below the running count still wraps promptly
  assign w_tick    = (tick_cnt_q >= (w_eff_div - 16'd1));

  always_comb begin
    state_d     = state_q;
    clock_div_d = clock_div_q;
    tick_cnt_d  = w_tick ? 16'd0 : (tick_cnt_q + 16'd1);
    os_cnt_d    = w_tick ? (os_cnt_q + 4'd1) : os_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_byte_d   = rx_byte_q;
    received_d  = 1'b0;
    rx_error_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_set_clock_div) begin
          clock_div_d = i_user_clock_div;
        end
        if (!w_rx) begin
          state_d    = S_START;
          tick_cnt_d = 16'd0;
          os_cnt_d   = 4'd0;
        end
      end
      S_START: begin
        if (w_tick && (os_cnt_q == 4'd7)) begin
          if (w_rx) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            bit_idx_d = 3'd0;
            os_cnt_d  = 4'd0;
          end
        end
      end
      S_DATA: begin
        if (w_tick && (os_cnt_q == 4'd15)) begin
          shift_d = {w_rx, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (w_tick && (os_cnt_q == 4'd15)) begin
          if (w_rx) begin
            rx_byte_d  = shift_q;
            received_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            rx_error_d = 1'b1;
            state_d    = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (w_rx) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      clock_div_q <= DEFAULT_CLOCK_DIV;
      tick_cnt_q  <= 16'd0;
      os_cnt_q    <= 4'd0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      rx_byte_q   <= 8'h00;
      received_q  <= 1'b0;
      rx_error_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= i_phy_uart_in;
      sync2_q     <= sync1_q;
      clock_div_q <= clock_div_d;
      tick_cnt_q  <= tick_cnt_d;
      os_cnt_q    <= os_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_byte_q   <= rx_byte_d;
      received_q  <= received_d;
      rx_error_q  <= rx_error_d;
    end
  end

  assign o_rx_byte      = rx_byte_q;
  assign o_received     = received_q;
  assign o_rx_error     = rx_error_q;
  assign o_is_receiving = (state_q != S_IDLE);
  assign o_clock_div    = clock_div_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_deframer.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_deframer: directed frame vectors plus corner-case sequences
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx_deframer;

  localparam int BIT_CLK = 64;

  logic        clk;
  logic        rst;
  logic        line;
  logic        set_div;
  logic [15:0] user_div;
  logic [7:0]  rx_byte;
  logic        received;
  logic        rx_error;
  logic        is_receiving;
  logic [15:0] clock_div;

  int tests;
  int fails;
  int cyc;
  int rcv_cnt;
  int err_cnt;
  int both_cnt;
  logic [7:0] rcv_bytes[$];
  int         rcv_cycs[$];

  uart_rx_deframer #(.DEFAULT_CLOCK_DIV(16'd4)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_phy_uart_in    (line),
    .i_set_clock_div  (set_div),
    .i_user_clock_div (user_div),
    .o_rx_byte        (rx_byte),
    .o_received       (received),
    .o_rx_error       (rx_error),
    .o_is_receiving   (is_receiving),
    .o_clock_div      (clock_div)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc > 60000) begin
      $display("FAIL watchdog: cycle %0d exceeded limit 60000", cyc);
      $fatal(1, "watchdog expired");
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (received) begin
        rcv_cnt <= rcv_cnt + 1;
        rcv_bytes.push_back(rx_byte);
        rcv_cycs.push_back(cyc);
      end
      if (rx_error) err_cnt <= err_cnt + 1;
      if (received && rx_error) both_cnt <= both_cnt + 1;
    end
  end

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    int         exp_rcv;
    int         exp_err;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t vecs[6];

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int bc);
    line = 1'b0;
    wait_clk(bc);
    for (int i = 0; i < 8; i++) begin
      line = d[i];
      wait_clk(bc);
    end
    line = stop_ok ? 1'b1 : 1'b0;
    wait_clk(bc);
  endtask

  initial begin
    int r0;
    int e0;
    int q0;
    tests = 0;
    fails = 0;
    cyc = 0;
    rcv_cnt = 0;
    err_cnt = 0;
    both_cnt = 0;
    rst = 1'b1;
    line = 1'b1;
    set_div = 1'b0;
    user_div = 16'd0;

    vecs[0] = '{8'h4C, 1'b1, 1, 0, 8'h4C};
    vecs[1] = '{8'hA5, 1'b0, 0, 1, 8'h4C};
    vecs[2] = '{8'h00, 1'b1, 1, 0, 8'h00};
    vecs[3] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
    vecs[4] = '{8'h81, 1'b1, 1, 0, 8'h81};
    vecs[5] = '{8'h00, 1'b0, 0, 1, 8'h81};

    wait_clk(3);
    check("rst_byte", {24'd0, rx_byte}, 32'h00);
    check("rst_received", {31'd0, received}, 32'd0);
    check("rst_error", {31'd0, rx_error}, 32'd0);
    check("rst_busy", {31'd0, is_receiving}, 32'd0);
    check("rst_div", {16'd0, clock_div}, 32'd4);
    rst = 1'b0;
    wait_clk(20);

    for (int v = 0; v < 6; v++) begin
      r0 = rcv_cnt;
      e0 = err_cnt;
      send_frame(vecs[v].data, vecs[v].stop_ok, BIT_CLK);
      if (!vecs[v].stop_ok) begin
        wait_clk(100);
        check($sformatf("v%0d_break_busy", v), {31'd0, is_receiving}, 32'd1);
        wait_clk(100);
        line = 1'b1;
      end
      wait_clk(150);
      check($sformatf("v%0d_rcv_count", v), rcv_cnt - r0, vecs[v].exp_rcv);
      check($sformatf("v%0d_err_count", v), err_cnt - e0, vecs[v].exp_err);
      check($sformatf("v%0d_byte", v), {24'd0, rx_byte}, {24'd0, vecs[v].exp_byte});
      check($sformatf("v%0d_idle", v), {31'd0, is_receiving}, 32'd0);
    end

    // glitch shorter than half a bit
    r0 = rcv_cnt;
    e0 = err_cnt;
    line = 1'b0;
    wait_clk(10);
    check("glitch_busy", {31'd0, is_receiving}, 32'd1);
    wait_clk(6);
    line = 1'b1;
    wait_clk(100);
    check("glitch_rcv", rcv_cnt - r0, 32'd0);
    check("glitch_err", err_cnt - e0, 32'd0);
    check("glitch_idle", {31'd0, is_receiving}, 32'd0);

    // back-to-back "30"
    q0 = rcv_bytes.size();
    send_frame(8'h33, 1'b1, BIT_CLK);
    send_frame(8'h30, 1'b1, BIT_CLK);
    wait_clk(150);
    check("b2b_count", rcv_bytes.size() - q0, 32'd2);
    if (rcv_bytes.size() - q0 == 2) begin
      check("b2b_byte0", {24'd0, rcv_bytes[q0]}, 32'h33);
      check("b2b_byte1", {24'd0, rcv_bytes[q0+1]}, 32'h30);
      check("b2b_spacing", rcv_cycs[q0+1] - rcv_cycs[q0], 32'd640);
    end

    // reset mid-frame at bit 4 of 0xFF
    line = 1'b0;
    wait_clk(BIT_CLK);
    line = 1'b1;
    wait_clk(4 * BIT_CLK + BIT_CLK / 2);
    rst = 1'b1;
    #2;
    check("mrst_byte", {24'd0, rx_byte}, 32'h00);
    check("mrst_busy", {31'd0, is_receiving}, 32'd0);
    check("mrst_div", {16'd0, clock_div}, 32'd4);
    wait_clk(3);
    rst = 1'b0;
    wait_clk(4 * BIT_CLK);
    r0 = rcv_cnt;
    e0 = err_cnt;
    send_frame(8'h12, 1'b1, BIT_CLK);
    wait_clk(150);
    check("mrst_rcv", rcv_cnt - r0, 32'd1);
    check("mrst_err", err_cnt - e0, 32'd0);
    check("mrst_after_byte", {24'd0, rx_byte}, 32'h12);

    // divider request mid-frame is ignored
    r0 = rcv_cnt;
    fork
      send_frame(8'h3C, 1'b1, BIT_CLK);
      begin
        wait_clk(300);
        set_div = 1'b1;
        user_div = 16'd8;
        wait_clk(1);
        set_div = 1'b0;
        wait_clk(2);
        check("div_busy_ignored", {16'd0, clock_div}, 32'd4);
      end
    join
    wait_clk(150);
    check("div_busy_rcv", rcv_cnt - r0, 32'd1);
    check("div_busy_byte", {24'd0, rx_byte}, 32'h3C);

    // divider load in IDLE, then 128 clk per bit
    set_div = 1'b1;
    user_div = 16'd8;
    wait_clk(1);
    set_div = 1'b0;
    wait_clk(2);
    check("div_idle", {16'd0, clock_div}, 32'd8);
    r0 = rcv_cnt;
    e0 = err_cnt;
    send_frame(8'h5A, 1'b1, 2 * BIT_CLK);
    wait_clk(300);
    check("div8_rcv", rcv_cnt - r0, 32'd1);
    check("div8_err", err_cnt - e0, 32'd0);
    check("div8_byte", {24'd0, rx_byte}, 32'h5A);

    check("never_both", both_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx_deframer.md
UART_RX_DEFRAMER -- requirements
Module: uart_rx_deframer

Purpose: serial receive front end that converts the host UART line into byte strobes for the ASCII command parser directly downstream.

Interface
- REQ-001 Parameter DEFAULT_CLOCK_DIV, default 16'd54: clk cycles per 16x oversample tick after reset.
- REQ-002 clk  input  1  sole clock; all logic on posedge clk.
- REQ-003 rst  input  1  asynchronous, active-high reset.
- REQ-004 i_phy_uart_in  input  1  asynchronous serial line (8N1, LSB first, idle high).
- REQ-005 i_set_clock_div  input  1  single-cycle request to load a new divider.
- REQ-006 i_user_clock_div  input  16  divider value loaded by i_set_clock_div.
- REQ-007 o_rx_byte  output  8  last correctly framed byte.
- REQ-008 o_received  output  1  one-cycle strobe: o_rx_byte is newly valid.
- REQ-009 o_rx_error  output  1  one-cycle strobe: framing error (stop bit sampled low).
- REQ-010 o_is_receiving  output  1  high in every state except IDLE.
- REQ-011 o_clock_div  output  16  divider currently in use.

Function
- REQ-012 i_phy_uart_in shall pass through a 2-flop synchronizer, reset to 1; all decisions use the synchronized value (2-cycle input latency).
- REQ-013 Tick generator: counter counts 0..div-1 and emits a tick when it wraps; a divider of 0 shall behave as 1.
- REQ-014 On entry to START the tick counter and the 4-bit oversample count shall clear, aligning ticks to the detected falling edge.
- REQ-015 States: IDLE, START, DATA, STOP, BREAK.
- REQ-016 IDLE: synchronized line low -> START.
- REQ-017 START: at oversample count 7 (mid start bit): line high -> IDLE with no strobe (glitch reject); line low -> DATA, with bit index and oversample count cleared.
- REQ-018 DATA: every 16th tick (mid-bit), shift the sampled bit into bit 7 of the shift register (LSB first); after bit index 7 is sampled -> STOP.
- REQ-019 STOP: at the 16th tick: line high -> o_rx_byte <= shift register, o_received = 1 for one cycle, -> IDLE; line low -> o_rx_error = 1 for one cycle, o_rx_byte unchanged, -> BREAK.
- REQ-020 BREAK: remain until the synchronized line is high, then -> IDLE; no strobes are issued in BREAK.
- REQ-021 o_received and o_rx_error shall never be high in the same cycle.
- REQ-022 o_rx_byte shall hold its value until the next good frame.
- REQ-023 i_set_clock_div shall be honoured only in IDLE; it is ignored in all other states.
- REQ-024 A falling edge in the same cycle as an IDLE divider load: the load takes effect and START uses the new divider.
- REQ-025 A new start edge is accepted in the first IDLE cycle after STOP, so back-to-back frames with one stop bit are received.

Reset
- REQ-026 Assertion of rst at any time, including mid-frame, shall immediately force: state IDLE, o_rx_byte 8'h00, o_received 0, o_rx_error 0, o_is_receiving 0, o_clock_div DEFAULT_CLOCK_DIV, synchronizer flops 1, and all counters and the shift register 0.
- REQ-027 After rst deasserts, a partial frame in progress shall be discarded; the next falling edge starts a fresh frame.

Verification (DEFAULT_CLOCK_DIV=4, so 64 clk per bit)
- REQ-028 Send 0x4C ('L') with a good stop bit -> exactly one o_received pulse, o_rx_byte = 8'h4C, no o_rx_error.
- REQ-029 Drive the line low for 16 clk, then high -> no o_received or o_rx_error; o_is_receiving returns low.
- REQ-030 Send 0xA5 with the stop bit held low, then release the line high after 200 clk -> one o_rx_error pulse, o_rx_byte keeps its previous value, and the state returns to IDLE only after the line goes high.
- REQ-031 Send "30" (0x33, 0x30) back to back -> two o_received pulses, 640 clk apart, carrying 8'h33 then 8'h30.
- REQ-032 Assert rst at bit 4 of 0xFF, release it, then send 0x12 -> outputs at reset values, then one o_received with 8'h12.
- REQ-033 Pulse i_set_clock_div with 16'd8 mid-frame -> o_clock_div stays 4 and the frame decodes correctly; repeat in IDLE -> o_clock_div = 8, and a 128-clk/bit frame of 0x5A decodes to 8'h5A.
